// File: rtl/lab3_pkg.sv
// Shared constants and the forwarding-source code for the ID/EX operand stage.
package lab3_pkg;
    localparam int WIDTH    = 64;
    localparam int ZERO_REG = 31;

    typedef enum logic [2:0] {
        FWD_ZERO,
        FWD_EX,
        FWD_EXMEM,
        FWD_MEMWB,
        FWD_RF
    } fwd_sel_t;
endpackage

// File: rtl/forward_select.sv
// One operand's bypass mux: picks the youngest in-flight producer of rs, else the regfile.
module forward_select #(
    parameter int WIDTH    = lab3_pkg::WIDTH,
    parameter int ZERO_REG = lab3_pkg::ZERO_REG
) (
    input  logic [4:0]       rs,
    input  logic             exEn,
    input  logic [4:0]       exRd,
    input  logic             exMemEn,
    input  logic [4:0]       exMemRd,
    input  logic             memWbEn,
    input  logic [4:0]       memWbRd,
    input  logic [WIDTH-1:0] exData,
    input  logic [WIDTH-1:0] exMemData,
    input  logic [WIDTH-1:0] memWbData,
    input  logic [WIDTH-1:0] rfData,
    output logic [WIDTH-1:0] value,
    output lab3_pkg::fwd_sel_t sel
);
    import lab3_pkg::*;

    localparam logic [4:0] ZR = 5'(ZERO_REG);

    always_comb begin
        if (rs == ZR)                        sel = FWD_ZERO;
        else if (exEn && exRd == rs)         sel = FWD_EX;
        else if (exMemEn && exMemRd == rs)   sel = FWD_EXMEM;
        else if (memWbEn && memWbRd == rs)   sel = FWD_MEMWB;
        else                                 sel = FWD_RF;
    end

    always_comb begin
        case (sel)
            FWD_EX:    value = exData;
            FWD_EXMEM: value = exMemData;
            FWD_MEMWB: value = memWbData;
            FWD_RF:    value = rfData;
            default:   value = '0;
        endcase
    end
endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX register with operand forwarding, load-use bubble insertion, stall and flush.
module id_ex_operand_stage #(
    parameter int WIDTH    = lab3_pkg::WIDTH,
    parameter int ZERO_REG = lab3_pkg::ZERO_REG
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [4:0]       ReadRegister1,
    input  logic [4:0]       ReadRegister2,
    input  logic             in_UseA,
    input  logic             in_UseB,
    input  logic [WIDTH-1:0] ReadData1,
    input  logic [WIDTH-1:0] ReadData2,
    input  logic [4:0]       in_Rd,
    input  logic             in_RegWrite,
    input  logic             in_MemRead,
    input  logic [WIDTH-1:0] ExAluResult,
    input  logic [4:0]       ExMemRd,
    input  logic             ExMemRegWrite,
    input  logic             ExMemMemRead,
    input  logic [WIDTH-1:0] ExMemResult,
    input  logic [4:0]       MemWbRd,
    input  logic             MemWbRegWrite,
    input  logic [WIDTH-1:0] MemWbData,
    input  logic             Stall,
    input  logic             Flush,
    output logic             ex_valid,
    output logic             ex_RegWrite,
    output logic             ex_MemRead,
    output logic [4:0]       ex_Rd,
    output logic [WIDTH-1:0] ex_A,
    output logic [WIDTH-1:0] ex_B,
    output logic             LoadUseHazard
);
    import lab3_pkg::*;

    localparam int         NUM_SRC = 2;
    localparam logic [4:0] ZR      = 5'(ZERO_REG);

    logic [NUM_SRC-1:0][4:0]       rsArr;
    logic [NUM_SRC-1:0][WIDTH-1:0] rfArr;
    logic [NUM_SRC-1:0][WIDTH-1:0] opVal;
    logic [NUM_SRC-1:0]            useArr;
    logic [NUM_SRC-1:0]            srcHaz;
    fwd_sel_t                      fwdSel [NUM_SRC];

    assign rsArr  = {ReadRegister2, ReadRegister1};
    assign rfArr  = {ReadData2, ReadData1};
    assign useArr = {in_UseB, in_UseA};

    // Loads never forward from EX or EX/MEM: their data does not exist until MEM/WB.
    logic exFwdEn, exMemFwdEn;
    assign exFwdEn    = ex_valid & ex_RegWrite & ~ex_MemRead;
    assign exMemFwdEn = ExMemRegWrite & ~ExMemMemRead;

    for (genvar g = 0; g < NUM_SRC; g++) begin : gSrc
        forward_select #(.WIDTH(WIDTH), .ZERO_REG(ZERO_REG)) uFwd (
            .rs        (rsArr[g]),
            .exEn      (exFwdEn),
            .exRd      (ex_Rd),
            .exMemEn   (exMemFwdEn),
            .exMemRd   (ExMemRd),
            .memWbEn   (MemWbRegWrite),
            .memWbRd   (MemWbRd),
            .exData    (ExAluResult),
            .exMemData (ExMemResult),
            .memWbData (MemWbData),
            .rfData    (rfArr[g]),
            .value     (opVal[g]),
            .sel       (fwdSel[g])
        );

        assign srcHaz[g] = useArr[g] && rsArr[g] != ZR &&
                           ((ex_valid && ex_MemRead && ex_Rd == rsArr[g]) ||
                            (ExMemRegWrite && ExMemMemRead && ExMemRd == rsArr[g]));

        always_comb begin
            assert (fwdSel[g] != FWD_ZERO || opVal[g] == '0);
        end
    end

    assign LoadUseHazard = in_valid & (|srcHaz);

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid    <= 1'b0;
            ex_RegWrite <= 1'b0;
            ex_MemRead  <= 1'b0;
            ex_Rd       <= '0;
            ex_A        <= '0;
            ex_B        <= '0;
        end else if (Flush || (!Stall && LoadUseHazard)) begin
            ex_valid    <= 1'b0;
            ex_RegWrite <= 1'b0;
            ex_MemRead  <= 1'b0;
            ex_Rd       <= ZR;
            ex_A        <= '0;
            ex_B        <= '0;
        end else if (!Stall) begin
            ex_valid    <= in_valid;
            ex_RegWrite <= in_RegWrite & in_valid;
            ex_MemRead  <= in_MemRead & in_valid;
            ex_Rd       <= in_Rd;
            ex_A        <= opVal[0];
            ex_B        <= opVal[1];
        end
    end
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench: directed scenarios plus random traffic against a behavioural model.
module tb_id_ex_operand_stage;
    logic        clk = 1'b0;
    logic        reset, in_valid, in_UseA, in_UseB, in_RegWrite, in_MemRead;
    logic [4:0]  ReadRegister1, ReadRegister2, in_Rd, ExMemRd, MemWbRd;
    logic [63:0] ReadData1, ReadData2, ExAluResult, ExMemResult, MemWbData;
    logic        ExMemRegWrite, ExMemMemRead, MemWbRegWrite, Stall, Flush;
    logic        ex_valid, ex_RegWrite, ex_MemRead, LoadUseHazard;
    logic [4:0]  ex_Rd;
    logic [63:0] ex_A, ex_B;

    always #5 clk = ~clk;

    id_ex_operand_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid),
        .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .in_UseA(in_UseA), .in_UseB(in_UseB),
        .ReadData1(ReadData1), .ReadData2(ReadData2),
        .in_Rd(in_Rd), .in_RegWrite(in_RegWrite), .in_MemRead(in_MemRead),
        .ExAluResult(ExAluResult),
        .ExMemRd(ExMemRd), .ExMemRegWrite(ExMemRegWrite), .ExMemMemRead(ExMemMemRead),
        .ExMemResult(ExMemResult),
        .MemWbRd(MemWbRd), .MemWbRegWrite(MemWbRegWrite), .MemWbData(MemWbData),
        .Stall(Stall), .Flush(Flush),
        .ex_valid(ex_valid), .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead),
        .ex_Rd(ex_Rd), .ex_A(ex_A), .ex_B(ex_B), .LoadUseHazard(LoadUseHazard)
    );

    typedef struct {
        logic        hz;
        logic        v, rw, mr;
        logic [4:0]  rd;
        logic [63:0] a, b;
    } exp_t;

    exp_t sb[$];
    exp_t m;   // model of the ID/EX register contents
    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Youngest writer of r wins; loads in EX or EX/MEM have no data yet.
    function automatic logic [63:0] srcVal(input logic [4:0] r, input logic [63:0] rf);
        if (r == 5'd31) return 64'd0;
        if (m.v && m.rw && !m.mr && m.rd == r) return ExAluResult;
        if (ExMemRegWrite && !ExMemMemRead && ExMemRd == r) return ExMemResult;
        if (MemWbRegWrite && MemWbRd == r) return MemWbData;
        return rf;
    endfunction

    function automatic logic pendingLoad(input logic use_, input logic [4:0] r);
        if (!use_ || r == 5'd31) return 1'b0;
        return (m.v && m.mr && m.rd == r) || (ExMemRegWrite && ExMemMemRead && ExMemRd == r);
    endfunction

    task automatic cyc();
        exp_t n;
        logic hz;
        hz = in_valid && (pendingLoad(in_UseA, ReadRegister1) || pendingLoad(in_UseB, ReadRegister2));
        n = m;
        if (reset) begin
            n.v = 0; n.rw = 0; n.mr = 0; n.rd = 0; n.a = 0; n.b = 0;
        end else if (Flush || (!Stall && hz)) begin
            n.v = 0; n.rw = 0; n.mr = 0; n.rd = 5'd31; n.a = 0; n.b = 0;
        end else if (!Stall) begin
            n.v = in_valid; n.rw = in_RegWrite && in_valid; n.mr = in_MemRead && in_valid;
            n.rd = in_Rd; n.a = srcVal(ReadRegister1, ReadData1); n.b = srcVal(ReadRegister2, ReadData2);
        end
        n.hz = hz;
        sb.push_back(n);
        m = n;
        @(posedge clk); #2;
    endtask

    task automatic clearIn();
        reset = 0; in_valid = 0; in_UseA = 0; in_UseB = 0; in_RegWrite = 0; in_MemRead = 0;
        ReadRegister1 = 0; ReadRegister2 = 0; in_Rd = 0; ReadData1 = 0; ReadData2 = 0;
        ExAluResult = 0; ExMemRd = 0; ExMemRegWrite = 0; ExMemMemRead = 0; ExMemResult = 0;
        MemWbRd = 0; MemWbRegWrite = 0; MemWbData = 0; Stall = 0; Flush = 0;
    endtask

    function automatic logic [4:0] pickReg();
        logic [4:0] r;
        r = 5'($urandom_range(0, 7));
        return (r == 5'd7) ? 5'd31 : r;
    endfunction

    // Monitor: hazard just before the edge, registers just after it.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk); #4;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("LoadUseHazard", LoadUseHazard, e.hz);
                @(posedge clk); #1;
                chk("ex_valid", ex_valid, e.v);
                chk("ex_RegWrite", ex_RegWrite, e.rw);
                chk("ex_MemRead", ex_MemRead, e.mr);
                chk("ex_Rd", ex_Rd, e.rd);
                chk("ex_A", ex_A, e.a);
                chk("ex_B", ex_B, e.b);
            end
        end
    end

    initial begin
        logic [63:0] held;
        m = '{hz: 0, v: 0, rw: 0, mr: 0, rd: 0, a: 0, b: 0};
        clearIn();
        reset = 1;
        @(posedge clk); #2;

        // reset and zero register
        cyc();
        chk("reset ex_valid", ex_valid, 0);
        chk("reset ex_A", ex_A, 0);
        reset = 0; in_valid = 1; ReadRegister1 = 31; in_UseA = 1; ReadData1 = 64'hA0;
        ExMemRd = 31; ExMemRegWrite = 1;
        cyc();
        chk("zero reg ex_A", ex_A, 0);
        chk("zero reg ex_valid", ex_valid, 1);

        // forwarding priority
        clearIn(); in_valid = 1; in_RegWrite = 1; in_Rd = 5;
        cyc();
        ReadRegister1 = 5; in_UseA = 1; ExAluResult = 64'h11;
        ExMemRd = 5; ExMemRegWrite = 1; ExMemResult = 64'h22;
        MemWbRd = 5; MemWbRegWrite = 1; MemWbData = 64'h33; ReadData1 = 64'h44;
        cyc();
        chk("prio EX", ex_A, 64'h11);
        in_RegWrite = 0;
        cyc();
        cyc();
        chk("prio EXMEM", ex_A, 64'h22);
        ExMemRegWrite = 0;
        cyc();
        chk("prio MEMWB", ex_A, 64'h33);
        MemWbRegWrite = 0;
        cyc();
        chk("prio RF", ex_A, 64'h44);

        // load-use: two bubbles, then MEM/WB data
        clearIn(); in_valid = 1; in_RegWrite = 1; in_MemRead = 1; in_Rd = 3;
        cyc();
        in_MemRead = 0; in_Rd = 4; ReadRegister1 = 3; in_UseA = 1; ReadData1 = 64'h1;
        #1 chk("load-use hz1", LoadUseHazard, 1);
        cyc();
        chk("bubble1", ex_valid, 0);
        ExMemRd = 3; ExMemRegWrite = 1; ExMemMemRead = 1;
        #1 chk("load-use hz2", LoadUseHazard, 1);
        cyc();
        chk("bubble2", ex_valid, 0);
        ExMemRegWrite = 0; ExMemMemRead = 0; MemWbRd = 3; MemWbRegWrite = 1; MemWbData = 64'hDEAD;
        cyc();
        chk("load-use data", ex_A, 64'hDEAD);

        // use masking
        clearIn(); in_valid = 1; in_RegWrite = 1; in_MemRead = 1; in_Rd = 3;
        cyc();
        in_MemRead = 0; in_Rd = 4; ReadRegister1 = 1; in_UseA = 1; ReadRegister2 = 3; in_UseB = 0;
        cyc();
        chk("use mask valid", ex_valid, 1);

        // stall holds, flush beats stall
        clearIn(); in_valid = 1; in_RegWrite = 1; in_Rd = 9; ReadRegister1 = 2; ReadData1 = 64'hBEEF;
        cyc();
        held = ex_A;
        Stall = 1;
        for (int i = 0; i < 3; i++) begin
            ReadData1 = {$urandom, $urandom}; in_Rd = 5'($urandom);
            cyc();
        end
        chk("stall hold A", ex_A, held);
        Flush = 1;
        cyc();
        chk("flush+stall valid", ex_valid, 0);
        chk("flush+stall Rd", ex_Rd, 31);

        // flush during load-use hazard
        clearIn(); in_valid = 1; in_RegWrite = 1; in_MemRead = 1; in_Rd = 6;
        cyc();
        in_MemRead = 0; in_Rd = 8; ReadRegister2 = 6; in_UseB = 1; Flush = 1;
        cyc();
        chk("flush hz bubble", ex_valid, 0);
        Flush = 0; in_valid = 0;
        #1 chk("flush hz clear", LoadUseHazard, 0);
        cyc();

        // write-through from MEM/WB
        clearIn(); in_valid = 1; ReadRegister1 = 7; in_UseA = 1; ReadData1 = 64'h5;
        MemWbRd = 7; MemWbRegWrite = 1; MemWbData = 64'h0000010204080001;
        cyc();
        chk("write-through", ex_A, 64'h0000010204080001);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 49) == 0);
            in_valid = ($urandom_range(0, 4) != 0);
            ReadRegister1 = pickReg(); ReadRegister2 = pickReg(); in_Rd = pickReg();
            in_UseA = $urandom; in_UseB = $urandom;
            in_RegWrite = $urandom; in_MemRead = ($urandom_range(0, 2) == 0);
            ReadData1 = {$urandom, $urandom}; ReadData2 = {$urandom, $urandom};
            ExAluResult = {$urandom, $urandom};
            ExMemRd = pickReg(); ExMemRegWrite = $urandom; ExMemMemRead = $urandom;
            ExMemResult = {$urandom, $urandom};
            MemWbRd = pickReg(); MemWbRegWrite = $urandom; MemWbData = {$urandom, $urandom};
            Stall = ($urandom_range(0, 7) == 0); Flush = ($urandom_range(0, 9) == 0);
            cyc();
        end

        clearIn();
        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/id_ex_operand_stage.md
# id_ex_operand_stage

ID/EX pipeline stage of the 64-bit LEGv8 datapath, directly downstream of `regfile`. It consumes `ReadData1`/`ReadData2` and resolves data hazards before the ALU sees the operands. Each operand is selected from one of four sources, in priority order: the in-flight EX result, the EX/MEM result, the MEM/WB write-back data, and finally the register file. X31 is always zero. The selected operands are latched into the ID/EX register. The block also detects load-use hazards, inserts bubbles, and honours external stall and flush requests.

## Interface
Parameters:
- `WIDTH`, 64: datapath width.
- `ZERO_REG`, 31: register index that always reads 0 and is never forwarded.

Ports:
- `clk` in 1: clock; all state updates on posedge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: ID holds a real instruction.
- `ReadRegister1`, `ReadRegister2` in 5: source indices presented to `regfile`.
- `in_UseA`, `in_UseB` in 1: instruction actually reads source 1 / source 2.
- `ReadData1`, `ReadData2` in WIDTH: `regfile` outputs.
- `in_Rd` in 5: destination index.
- `in_RegWrite`, `in_MemRead` in 1: destination write / load control.
- `ExAluResult` in WIDTH: combinational ALU output for the instruction held in this stage.
- `ExMemRd` in 5, `ExMemRegWrite` in 1, `ExMemMemRead` in 1, `ExMemResult` in WIDTH: EX/MEM register contents.
- `MemWbRd` in 5, `MemWbRegWrite` in 1, `MemWbData` in WIDTH: write-back bus (the same values driven to `regfile` WriteRegister/RegWrite/WriteData).
- `Stall` in 1: downstream hold.
- `Flush` in 1: squash the ID instruction (branch taken).
- `ex_valid`, `ex_RegWrite`, `ex_MemRead` out 1: registered controls.
- `ex_Rd` out 5: registered destination.
- `ex_A`, `ex_B` out WIDTH: registered operands.
- `LoadUseHazard` out 1: combinational; upstream must hold PC and IF/ID while it is high.

## Operation
- **Operand selection per source *s* with index `rs`, first match wins:**
  1. `rs == ZERO_REG`: result is 0.
  2. EX match: `ex_valid & ex_RegWrite & !ex_MemRead & ex_Rd == rs` selects `ExAluResult`.
  3. EX/MEM match: `ExMemRegWrite & !ExMemMemRead & ExMemRd == rs` selects `ExMemResult`.
  4. MEM/WB match: `MemWbRegWrite & MemWbRd == rs` selects `MemWbData`. This covers the cycle in which `regfile` has not yet committed the write.
  5. Otherwise: `ReadData1` / `ReadData2`.
- **LoadUseHazard** is high when `in_valid` and, for either source with Use set and `rs != ZERO_REG`, either of these holds:
  - `ex_valid & ex_MemRead & ex_Rd == rs`
  - `ExMemRegWrite & ExMemMemRead & ExMemRd == rs`
- **Register update priority, evaluated each posedge:**
  1. `reset`: all outputs 0.
  2. `Flush`: load a bubble.
  3. `Stall`: hold all registers.
  4. `LoadUseHazard`: load a bubble.
  5. Otherwise: capture `in_valid`, controls, `in_Rd`, and the forwarded A/B.
- **Bubble** means `ex_valid = 0`, `ex_RegWrite = 0`, `ex_MemRead = 0`, `ex_Rd = ZERO_REG`, `ex_A = 0`, `ex_B = 0`.
- **Squashed controls:** captured `ex_RegWrite` and `ex_MemRead` are ANDed with `in_valid`, so an invalid ID slot never forwards or triggers a hazard.
- A destination of `ZERO_REG` never forwards, because rule 1 wins.

## Timing
- Latency: 1 cycle from ID inputs to `ex_*`.
- A load followed immediately by a dependent instruction costs 2 bubbles. The load passes through EX, then EX/MEM, and the dependent instruction then picks up `MemWbData`.
- `LoadUseHazard` is purely combinational from current inputs and state. It is still computed during `Stall`, but has no effect on state while `Stall` is high.
- Flush and Stall in the same cycle: flush wins, so a bubble is loaded.
- Reset mid-operation: the next posedge clears all state, and `LoadUseHazard` deasserts because `ex_*` is 0.

## Structure
- **Package `lab3_pkg`:**
  - `WIDTH` and `ZERO_REG` constants.
  - Enum `fwd_sel_t` {`FWD_ZERO`, `FWD_EX`, `FWD_EXMEM`, `FWD_MEMWB`, `FWD_RF`}.
- **Sub-module `forward_select`:** instantiated twice, once per source.
  - Inputs: `rs`, the match inputs, and the four data candidates.
  - Outputs: the selected WIDTH-bit value and the `fwd_sel_t` code, which is exposed for the bench.
- The top level holds the hazard detection logic and the ID/EX register.

## Test plan
- **Reset and zero register:** assert reset, then `ReadRegister1 = 31`, `ReadData1 = 64'hA0`, `ExMemRd = 31` with `ExMemRegWrite = 1` → after one cycle `ex_A = 0`, `ex_valid = 1`.
- **Forwarding priority:** `rs1 = 5` matches EX (`ExAluResult = 64'h11`), EX/MEM (`64'h22`) and MEM/WB (`64'h33`), with `ReadData1 = 64'h44` → `ex_A = 64'h11`. Remove the EX match → `64'h22`. Remove the EX/MEM match → `64'h33`. Remove the MEM/WB match → `64'h44`.
- **Load-use:**
  - Load to X3 captured in this stage; next instruction uses X3 → `LoadUseHazard = 1` for 2 cycles and 2 bubbles (`ex_valid = 0`).
  - The dependent instruction then captures `ex_A = MemWbData = 64'hDEAD`.
- **Use masking:** same load to X3, but `in_UseB = 0` with `rs2 = 3` → no hazard and no bubble.
- **Stall vs flush:**
  - Stall for 3 cycles → `ex_*` unchanged.
  - Flush together with Stall → next cycle is a bubble.
  - Flush alone during a load-use hazard → a bubble, and the hazard clears once the ID instruction is squashed.
- **Write-through:** MEM/WB writing `64'h0000010204080001` to X7 in the same cycle that ID reads X7, with `ReadData1` still holding the old value → `ex_A = 64'h0000010204080001`.
